// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared types and constants for the two-digit BCD countdown
//               timer (state encoding, BCD limits, preset clamp helper).
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Out-of-range preset digits saturate to 9 so the count stays legal BCD
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_down_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down_digit
// Description : Single BCD decade down-counter with synchronous load,
//               decrement-on-enable (0 wraps to 9) and combinational borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_digit
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             mr,
  input  logic             ld,
  input  logic [BCD_W-1:0] d,
  input  logic             en,
  output logic [BCD_W-1:0] q,
  output logic             bo
);

  // Digit register: load has priority over decrement
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      q <= '0;
    end else if (ld) begin
      q <= d;
    end else if (en) begin
      q <= (q == '0) ? BCD_MAX : q - 1'b1;
    end
  end

  // Borrow out feeds the enable of the next more significant digit
  assign bo = en & (q == '0);

endmodule
`default_nettype wire

// File: rtl/countdown_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_ctrl
// Description : Two-digit BCD countdown timer controller. Owns the FSM, the
//               tick divider, preset clamping and load/enable sequencing of
//               the two cascaded digit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             mr,
  input  logic             tick,
  input  logic             load,
  input  logic [BCD_W-1:0] preset_t,
  input  logic [BCD_W-1:0] preset_o,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [BCD_W-1:0] q_t,
  output logic [BCD_W-1:0] q_o,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  localparam logic [7:0] c_div_last = 8'(TICK_DIV - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_div;
  logic [7:0]       w_div_nxt;
  logic             w_ld_cmd;
  logic             w_ld;
  logic [BCD_W-1:0] w_d_t;
  logic [BCD_W-1:0] w_d_o;
  logic             w_dec;
  logic             w_bo_o;
  logic             w_bo_t;
  logic             w_zero;
  logic             w_last_dec;

  assign w_zero     = (q_t == '0) && (q_o == '0);
  assign w_last_dec = (q_t == '0) && (q_o == 4'd1);

  // A borrow out of the tens digit would mean wrapping below 00; force a
  // reload of 00 instead so the count can never underflow.
  assign w_ld = w_ld_cmd | w_bo_t;

  // Next-state, divider and digit load/enable decode
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_ld_cmd    = 1'b0;
    w_d_t       = '0;
    w_d_o       = '0;
    w_dec       = 1'b0;
    case (r_state)
      IDLE: begin
        if (abort) begin
          w_ld_cmd  = 1'b1;
          w_div_nxt = '0;
        end else if (start) begin
          // start is judged on the current count; a same-cycle load is dropped
          if (!w_zero) begin
            w_state_nxt = RUN;
            w_div_nxt   = '0;
          end
        end else if (load) begin
          w_ld_cmd = 1'b1;
          w_d_t    = bcd_clamp(preset_t);
          w_d_o    = bcd_clamp(preset_o);
        end
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_ld_cmd    = 1'b1;
          w_div_nxt   = '0;
        end else if (pause) begin
          // A coincident tick is dropped; divider holds its phase
          w_state_nxt = PAUSE;
        end else if (tick) begin
          if (r_div == c_div_last) begin
            w_div_nxt = '0;
            w_dec     = 1'b1;
            if (w_last_dec) begin
              w_state_nxt = DONE;
            end
          end else begin
            w_div_nxt = r_div + 8'd1;
          end
        end
      end
      PAUSE: begin
        if (abort) begin
          w_state_nxt = IDLE;
          w_ld_cmd    = 1'b1;
          w_div_nxt   = '0;
        end else if (start) begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        // Count is already 00 here; abort and the normal exit coincide
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, divider and registered status flags
  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      r_state <= IDLE;
      r_div   <= '0;
      busy    <= 1'b0;
      paused  <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      busy    <= (w_state_nxt == RUN) || (w_state_nxt == PAUSE);
      paused  <= (w_state_nxt == PAUSE);
      done    <= (w_state_nxt == DONE);
    end
  end

  bcd_down_digit u_ones (
    .clk (clk),
    .mr  (mr),
    .ld  (w_ld),
    .d   (w_d_o),
    .en  (w_dec),
    .q   (q_o),
    .bo  (w_bo_o)
  );

  bcd_down_digit u_tens (
    .clk (clk),
    .mr  (mr),
    .ld  (w_ld),
    .d   (w_d_t),
    .en  (w_bo_o),
    .q   (q_t),
    .bo  (w_bo_t)
  );

endmodule
`default_nettype wire

// File: doc/countdown_timer_ctrl.md
# countdown_timer_ctrl

Two-digit BCD countdown timer controller (00–99) that sequences a cascade of decade down-counter digits. It accepts a preset, runs on an external `tick` strobe, and supports pause/resume and abort. It signals a one-cycle `done` when the count reaches 00. The block sits between the front-panel/command logic and the digit display decoders, and owns all enable/load sequencing of the digit counters.

## Interface
- `TICK_DIV`, default 1: number of `tick` strobes per decrement. Legal range 1–255. A value of 1 means every tick decrements.
- `clk`  in  1  system clock; all state changes on rising edge.
- `mr`  in  1  master reset; asynchronous, active-high.
- `tick`  in  1  single-cycle timebase strobe, synchronous to `clk`.
- `load`  in  1  capture `preset_t`/`preset_o` into the count (IDLE only).
- `preset_t`  in  4  tens-digit preset, BCD.
- `preset_o`  in  4  ones-digit preset, BCD.
- `start`  in  1  begin counting (from IDLE) or resume (from PAUSE).
- `pause`  in  1  suspend counting (RUN only).
- `abort`  in  1  stop and clear to 00 (any state).
- `q_t`  out  4  tens digit, BCD.
- `q_o`  out  4  ones digit, BCD.
- `busy`  out  1  high in RUN or PAUSE.
- `paused`  out  1  high in PAUSE.
- `done`  out  1  one-cycle pulse when the countdown completes.

## Operation
- **FSM states:** IDLE, RUN, PAUSE, DONE. All are registered.
- **Reset value:** `mr` forces IDLE. It also clears `q_t`, `q_o`, the tick divider, `busy`, `paused` and `done` to 0 immediately, without waiting for a clock edge.
- **Command priority,** evaluated each cycle: `abort` > `pause` > `start` > `load`.
- **IDLE:**
  - `load` sets the count from the presets. A preset digit >9 is clamped to 9.
  - `start` goes to RUN only if the count ≠ 00. With a count of 00, `start` is ignored.
  - `load` and `start` in the same cycle: `start` is evaluated against the old count, and the new preset is not captured.
- **RUN:**
  - Each `tick` advances the divider. When the divider reaches `TICK_DIV`-1 on a tick, it wraps to 0 and the count decrements by one.
  - Decrement rule:
    - if ones ≠ 0, ones − 1;
    - else ones ← 9 and tens ← tens − 1.
  - The decrement that produces 00 moves the FSM to DONE on the same edge.
  - `pause` → PAUSE; the divider holds.
  - `abort` → IDLE, with count and divider cleared.
  - `load` is ignored.
- **PAUSE:**
  - Count and divider hold, and `tick` is ignored.
  - `start` → RUN.
  - `abort` → IDLE and clear.
  - `load` and `pause` are ignored.
- **DONE:**
  - `done` = 1 for exactly this one cycle. The count reads 00.
  - The next edge goes unconditionally to IDLE.
  - `abort` in DONE also goes to IDLE; `done` still completes its single cycle.
- **Simultaneous events in RUN:**
  - `tick` + `pause`: pause wins and the tick is dropped. The divider and count are unchanged.
  - `tick` + `abort`: abort wins.
- **Width rules:**
  - Digits are always legal BCD 0–9. The count never wraps below 00.
  - The divider is 8 bits wide.

## Timing
- All outputs are registered, with no combinational input-to-output paths.
- **Latency:**
  - `tick` sampled at edge N → new count visible after edge N.
  - `load` at edge N → presets visible after edge N.
  - `start` at edge N → `busy` = 1 after edge N.
- **Completion:** `done` is high in the cycle following the edge at which the count became 00. `busy` drops on the same edge at which `done` rises.
- **Input pulse widths:** command inputs are level-sampled every edge and need no minimum width. A held `start` in RUN has no effect.
- **Reset mid-operation:** `mr` asserted during RUN or PAUSE aborts without a `done` pulse. Release is synchronous to the next edge, leaving the block in IDLE with count 00.

## Structure
- **Shared package `timer_pkg`:**
  - state enum (IDLE, RUN, PAUSE, DONE);
  - `BCD_MAX` = 4'd9;
  - `BCD_W` = 4.
- **Sub-module `bcd_down_digit`,** instantiated twice:
  - Ports: `clk`, `mr`, `ld`, `d[3:0]`, `en`, `q[3:0]`, `bo`.
  - Behaviour: synchronous load, decrement on `en`, wrap 0→9.
  - `bo` = `en` & (`q` == 0), combinational borrow into the tens digit's `en`.
- **Controller:** owns the FSM, divider, clamping and the `ld`/`en` generation.

## Test plan
- **Basic run:** reset, then load 0x12 (tens 1, ones 2), `start`, then 12 ticks with `TICK_DIV`=1 → count 11,10,09…01,00. `done` is high for exactly 1 cycle after the 12th tick, then IDLE with `busy` = 0.
- **Clamp and zero start:**
  - load tens=0xC, ones=0xF → count 99.
  - Separately, `start` with count 00 → stays IDLE with no `done`.
- **Pause/resume:** load 05, start, 2 ticks (count 03), `pause`, then 5 ticks → count stays 03 and `paused` = 1. `start`, then 3 ticks → `done`.
- **Collision priority:**
  - `tick` + `pause` on the same edge at count 07 → count remains 07, state PAUSE.
  - `tick` + `abort` → count 00, state IDLE, no `done`.
- **Divider and async reset:**
  - `TICK_DIV`=3, load 02, start → decrements after the 3rd and 6th ticks, with `done` after the 6th.
  - Assert `mr` mid-cycle during RUN → outputs are 0 before the next edge, with no `done`.
